mem_access_ctrl: RTL and testbench

- Sits directly upstream of the word-wide data memory (negedge-clocked RAM, single write enable, word address = byte address[15:2]).
- Turns CPU load/store requests of byte, halfword or word size into word accesses.
- Performs read-modify-write for sub-word stores and lane extraction with sign/zero extension for sub-word loads.
- Stalls the CPU for one cycle per sub-word store and counts misaligned accesses.

---
 rtl/mem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Byte/halfword/word load-store adapter in front of a word-wide, negedge-written data RAM.
// Latency: loads and word stores complete in the request cycle; sub-word stores take 2 cycles (read, then merged write).
// Backpressure: stall is high for the single read cycle of a sub-word store; misaligned requests are dropped without stalling.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   req_read, req_write      CPU load/store request (held while stall=1); write wins if both are high
//   size, sign_ext           access size (00 byte, 01 half, 1x word) and load extension mode
//   addr, wdata, rdata       CPU byte address, store data (sub-word in low bits), load result
//   stall                    CPU must hold PC and request this cycle
//   misalign_err, err_count  current request misaligned; saturating count of misaligned requests
//   mem_write, mem_addr      data RAM write enable and word-aligned byte address
//   mem_wdata, mem_rdata     data RAM write word and read word (valid late in the cycle)
module mem_access_ctrl #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_read,
   input  logic                 req_write,
   input  logic [1:0]           size,
   input  logic                 sign_ext,
   input  logic [31:0]          addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   output logic                 stall,
   output logic                 misalign_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 mem_write,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   input  logic [31:0]          mem_rdata
);

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] merge_reg;
   logic [31:0] merge_nxt;
   logic [29:0] addr_reg;
   logic        req_any;
   logic        is_word;
   logic        is_half;
   logic        misaligned;
   logic        capture;
   logic        err_inc;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [31:0] load_val;

   assign req_any    = req_read | req_write;
   assign is_word    = size[1];              // 11 behaves as a word access
   assign is_half    = (size == 2'b01);
   assign misaligned = req_any & ((is_half & addr[0]) |
                                  (is_word & (addr[1:0] != 2'b00)));

   // Load lane extraction from the word currently presented by the RAM.
   always_comb begin
      byte_val = mem_rdata[7:0];
      case (addr[1:0])
         2'd0:    byte_val = mem_rdata[7:0];
         2'd1:    byte_val = mem_rdata[15:8];
         2'd2:    byte_val = mem_rdata[23:16];
         default: byte_val = mem_rdata[31:24];
      endcase
      half_val = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size)
         2'b00:   load_val = {{24{sign_ext & byte_val[7]}}, byte_val};
         2'b01:   load_val = {{16{sign_ext & half_val[15]}}, half_val};
         default: load_val = mem_rdata;
      endcase
   end

   // Merged word for a sub-word store: old RAM word with the target lane(s) replaced.
   always_comb begin
      merge_nxt = mem_rdata;
      if (is_half) begin
         if (addr[1]) merge_nxt[31:16] = wdata[15:0];
         else         merge_nxt[15:0]  = wdata[15:0];
      end else begin
         merge_nxt[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      end
   end

   // Next state and outputs. The MERGE write is driven from state, so an
   // asynchronous reset in MERGE removes mem_write before the RAM's negedge.
   always_comb begin
      state_nxt    = state;
      mem_write    = 1'b0;
      mem_addr     = {addr[31:2], 2'b00};
      mem_wdata    = wdata;
      stall        = 1'b0;
      rdata        = 32'h0;
      misalign_err = 1'b0;
      capture      = 1'b0;
      err_inc      = 1'b0;
      case (state)
         IDLE: begin
            if (misaligned) begin
               misalign_err = 1'b1;
               err_inc      = 1'b1;
            end else if (req_write) begin
               if (is_word) begin
                  mem_write = 1'b1;
               end else begin
                  // Read phase of read-modify-write: hold the CPU one cycle.
                  stall     = 1'b1;
                  capture   = 1'b1;
                  state_nxt = MERGE;
               end
            end else if (req_read) begin
               rdata = load_val;
            end
         end
         MERGE: begin
            // Request inputs still carry the held store; it retires here.
            mem_write = 1'b1;
            mem_addr  = {addr_reg, 2'b00};
            mem_wdata = merge_reg;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         merge_reg <= 32'h0;
         addr_reg  <= 30'h0;
         err_count <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            merge_reg <= merge_nxt;
            addr_reg  <= addr[31:2];
         end
         if (err_inc && (err_count != {ERR_CNT_W{1'b1}}))
            err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed sequences, a load vector table, and
// randomized traffic against a word-array reference model.
module tb_mem_access_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_read, req_write, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
   logic        stall, misalign_err, mem_write;
   logic [7:0]  err_count;

   int n_pass = 0;
   int n_total = 0;
   int exp_err = 0;

   always #5 clock = ~clock;

   mem_access_ctrl #(.ERR_CNT_W(8)) dut (
      .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write),
      .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
      .rdata(rdata), .stall(stall), .misalign_err(misalign_err),
      .err_count(err_count), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Data RAM: negedge write, asynchronous read.
   logic [31:0] ram [0:16383];
   initial for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
   always @(negedge clock) if (mem_write) ram[mem_addr[15:2]] <= mem_wdata;
   assign mem_rdata = ram[mem_addr[15:2]];

   // Reference memory for the random region 0x1000..0x103F.
   logic [31:0] ref_mem [0:15];

   typedef struct {
      logic [1:0]  sz;
      logic        se;
      logic [1:0]  off;
      logic [31:0] exp_rd;
      logic        exp_mis;
   } ld_vec_t;
   ld_vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic se, input logic [31:0] a, input logic [31:0] wd);
      req_read = rd; req_write = wr; size = sz; sign_ext = se; addr = a; wdata = wd;
   endtask

   task automatic idle();
      req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] wd);
      req(1'b0, 1'b1, 2'b10, 1'b0, a, wd);
      step();
   endtask

   task automatic err_tick();
      if (exp_err < 255) exp_err++;
   endtask

   // Load result computed from the architectural rules.
   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic se, input logic [1:0] lane);
      logic [31:0] v;
      if (sz == 2'b00) begin
         v = (w >> (8 * lane)) & 32'hFF;
         if (se && v >= 32'h80) v = v + 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
         v = (w >> (16 * lane[1])) & 32'hFFFF;
         if (se && v >= 32'h8000) v = v + 32'hFFFF0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] lane, input logic [31:0] wd);
      logic [31:0] m;
      int sh;
      if (sz == 2'b00) begin
         sh = 8 * lane;
         m = 32'hFF << sh;
      end else begin
         sh = 16 * lane[1];
         m = 32'hFFFF << sh;
      end
      return (w & ~m) | ((wd << sh) & m);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic        rd, wr, se, mis;
      logic [1:0]  sz;
      logic [31:0] a, wd, nw;

      tbl[0]  = '{2'b00, 1'b1, 2'd0, 32'h00000001, 1'b0};
      tbl[1]  = '{2'b00, 1'b1, 2'd1, 32'h0000007F, 1'b0};
      tbl[2]  = '{2'b00, 1'b1, 2'd2, 32'hFFFFFFFF, 1'b0};
      tbl[3]  = '{2'b00, 1'b0, 2'd3, 32'h00000080, 1'b0};
      tbl[4]  = '{2'b00, 1'b1, 2'd3, 32'hFFFFFF80, 1'b0};
      tbl[5]  = '{2'b01, 1'b1, 2'd0, 32'h00007F01, 1'b0};
      tbl[6]  = '{2'b01, 1'b0, 2'd2, 32'h000080FF, 1'b0};
      tbl[7]  = '{2'b01, 1'b1, 2'd2, 32'hFFFF80FF, 1'b0};
      tbl[8]  = '{2'b01, 1'b0, 2'd1, 32'h00000000, 1'b1};
      tbl[9]  = '{2'b10, 1'b1, 2'd0, 32'h80FF7F01, 1'b0};
      tbl[10] = '{2'b11, 1'b0, 2'd0, 32'h80FF7F01, 1'b0};
      tbl[11] = '{2'b10, 1'b0, 2'd2, 32'h00000000, 1'b1};
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

      // Reset state
      reset = 1'b1;
      idle();
      #3;
      chk("rst_mem_write", mem_write, 0);
      chk("rst_stall", stall, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_misalign", misalign_err, 0);
      chk("rst_err_count", err_count, 0);
      step();
      reset = 1'b0;

      // Word store then load
      req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      #3;
      chk("sw_mem_write", mem_write, 1);
      chk("sw_stall", stall, 0);
      chk("sw_mem_addr", mem_addr, 32'h10);
      chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
      step();
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      #3;
      chk("lw_rdata", rdata, 32'hDEADBEEF);
      chk("lw_stall", stall, 0);
      step();

      // Byte store read-modify-write
      sw(32'h10, 32'h11223344);
      req(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
      #3;
      chk("sb_c1_stall", stall, 1);
      chk("sb_c1_mem_write", mem_write, 0);
      step();
      #3;
      chk("sb_c2_mem_write", mem_write, 1);
      chk("sb_c2_stall", stall, 0);
      chk("sb_c2_mem_addr", mem_addr, 32'h10);
      chk("sb_c2_mem_wdata", mem_wdata, 32'h11AA3344);
      step();
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      #3;
      chk("sb_readback", rdata, 32'h11AA3344);
      step();

      // Single misaligned store
      chk("mis_err_before", err_count, 0);
      req(1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h12345678);
      #3;
      chk("mis_flag", misalign_err, 1);
      chk("mis_mem_write", mem_write, 0);
      chk("mis_stall", stall, 0);
      step();
      err_tick();
      chk("mis_err_after", err_count, exp_err);
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      #3;
      chk("mis_mem_kept", rdata, 32'h11AA3344);
      step();

      // Load table from 0x80FF7F01 at 0x40
      sw(32'h40, 32'h80FF7F01);
      foreach (tbl[i]) begin
         req(1'b1, 1'b0, tbl[i].sz, tbl[i].se, 32'h40 + {30'h0, tbl[i].off}, 32'h0);
         #3;
         chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_misalign", i), misalign_err, tbl[i].exp_mis);
         chk($sformatf("tbl%0d_stall", i), stall, 0);
         step();
         if (tbl[i].exp_mis) err_tick();
         chk($sformatf("tbl%0d_err_count", i), err_count, exp_err);
      end

      // Reset during the MERGE cycle of a halfword store
      sw(32'h20, 32'hCAFEF00D);
      req(1'b0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h00001234);
      #3;
      chk("rm_c1_stall", stall, 1);
      step();
      #1;
      chk("rm_c2_mem_write", mem_write, 1);
      reset = 1'b1;
      #1;
      chk("rm_mem_write_dropped", mem_write, 0);
      exp_err = 0;
      idle();
      step();
      reset = 1'b0;
      chk("rm_err_cleared", err_count, 0);
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      #3;
      chk("rm_mem_unchanged", rdata, 32'hCAFEF00D);
      chk("rm_idle_no_write", mem_write, 0);
      chk("rm_idle_no_stall", stall, 0);
      step();

      // Simultaneous read and write: write wins
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h01020304);
      #3;
      chk("rw_mem_write", mem_write, 1);
      chk("rw_rdata", rdata, 0);
      step();
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      #3;
      chk("rw_readback", rdata, 32'h01020304);
      step();

      // Back-to-back byte stores
      req(1'b0, 1'b1, 2'b00, 1'b0, 32'h30, 32'h000000AA);
      #3;
      chk("b2b_1_stall", stall, 1);
      step();
      #3;
      chk("b2b_1_wdata", mem_wdata, 32'h010203AA);
      step();
      req(1'b0, 1'b1, 2'b00, 1'b0, 32'h31, 32'h000000BB);
      #3;
      chk("b2b_2_stall", stall, 1);
      step();
      #3;
      chk("b2b_2_wdata", mem_wdata, 32'h0102BBAA);
      step();
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      #3;
      chk("b2b_readback", rdata, 32'h0102BBAA);
      step();

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         rd = 1'($urandom);
         wr = 1'($urandom);
         sz = 2'($urandom);
         se = 1'($urandom);
         a  = 32'h1000 + $urandom_range(0, 63);
         wd = $urandom;
         mis = (rd | wr) && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
         req(rd, wr, sz, se, a, wd);
         #3;
         chk("rnd_misalign", misalign_err, mis);
         if (mis) begin
            chk("rnd_mis_write", mem_write, 0);
            chk("rnd_mis_rdata", rdata, 0);
            step();
            err_tick();
         end else if (wr && sz[1]) begin
            chk("rnd_sw_write", mem_write, 1);
            chk("rnd_sw_stall", stall, 0);
            ref_mem[a[5:2]] = wd;
            step();
         end else if (wr) begin
            chk("rnd_sub_stall", stall, 1);
            chk("rnd_sub_c1_write", mem_write, 0);
            nw = ref_store(ref_mem[a[5:2]], sz, a[1:0], wd);
            ref_mem[a[5:2]] = nw;
            step();
            #3;
            chk("rnd_sub_c2_write", mem_write, 1);
            chk("rnd_sub_c2_wdata", mem_wdata, nw);
            chk("rnd_sub_c2_addr", mem_addr, {a[31:2], 2'b00});
            step();
         end else if (rd) begin
            chk("rnd_ld_rdata", rdata, ref_load(ref_mem[a[5:2]], sz, se, a[1:0]));
            chk("rnd_ld_stall", stall, 0);
            step();
         end else begin
            chk("rnd_idle_rdata", rdata, 0);
            chk("rnd_idle_write", mem_write, 0);
            chk("rnd_idle_stall", stall, 0);
            step();
         end
         chk("rnd_err_count", err_count, exp_err);
      end

      // Saturation after 300 misaligned requests
      req(1'b1, 1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
      for (int n = 0; n < 300; n++) begin
         step();
         err_tick();
      end
      chk("sat_err_model", err_count, exp_err);
      chk("sat_err_255", err_count, 255);
      idle();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
